// File: rtl/video_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// video_frame_scheduler_if
//
// Groups the writer handshake, the timing-generator controls and the status
// outputs of video_frame_scheduler into one bundle.
//
//   slave  : the scheduler. It receives requests and ticks, and drives grants,
//            indices, generator controls and status.
//   master : the surrounding system (frame writer, timing generator, bench).
//
// Signals
//   mode_oneshot  0 = continuous trigger, 1 = trigger per completed frame
//   wr_req        writer requests a buffer (level)
//   wr_grant      one-cycle pulse, wr_idx now owned by the writer
//   wr_idx        buffer being written
//   wr_done       pulse, current write buffer complete
//   wr_drop       pulse, abort current write and discard the buffer
//   frame_tick    pulse ahead of the generator's frame-start sample of ready
//   tg_ready      generator ready input
//   tg_trigger    generator trigger input
//   rd_idx        buffer the generator is reading
//   rd_valid      rd_idx holds a displayed buffer
//   overrun       one-cycle pulse, a completed undisplayed frame was reused
//   skip_cnt      saturating count of frames with tg_ready driven low
// -----------------------------------------------------------------------------
interface video_frame_scheduler_if #(
   parameter int IDX_BITS = 2
);
   logic                mode_oneshot;
   logic                wr_req;
   logic                wr_grant;
   logic [IDX_BITS-1:0] wr_idx;
   logic                wr_done;
   logic                wr_drop;
   logic                frame_tick;
   logic                tg_ready;
   logic                tg_trigger;
   logic [IDX_BITS-1:0] rd_idx;
   logic                rd_valid;
   logic                overrun;
   logic [15:0]         skip_cnt;

   modport slave (
      input  mode_oneshot, wr_req, wr_done, wr_drop, frame_tick,
      output wr_grant, wr_idx, tg_ready, tg_trigger, rd_idx, rd_valid,
             overrun, skip_cnt
   );

   modport master (
      output mode_oneshot, wr_req, wr_done, wr_drop, frame_tick,
      input  wr_grant, wr_idx, tg_ready, tg_trigger, rd_idx, rd_valid,
             overrun, skip_cnt
   );
endinterface

// File: rtl/video_frame_scheduler.sv
// -----------------------------------------------------------------------------
// video_frame_scheduler
//
// Schedules a ring of NUM_BUF frame buffers between one frame writer and the
// video timing generator. Free buffers are granted to the writer; on each
// frame_tick the newest completed buffer is promoted to the read side. The
// generator's ready (per-frame skip) and trigger inputs are driven from here.
//
// Ports
//   clk_in   clock
//   reset    asynchronous, active-high reset
//   sif      video_frame_scheduler_if.slave (writer handshake, generator
//            controls, read index, overrun pulse, skip counter)
//
// Optional feature (compile-time macro REPEAT_LAST_EN):
//   When defined, a frame_tick with no new frame but a displayed buffer keeps
//   that buffer, raises tg_ready and does not count a skip.
// -----------------------------------------------------------------------------
module video_frame_scheduler #(
   parameter int NUM_BUF  = 3,
   parameter int IDX_BITS = 2
) (
   input  logic                   clk_in,
   input  logic                   reset,
   video_frame_scheduler_if.slave sif
);

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_WRITING = 2'd1,
      BUF_FULL    = 2'd2,
      BUF_READING = 2'd3
   } buf_state_t;

   // Per-buffer status, published by the per-buffer state machines below
   logic [NUM_BUF-1:0]  free_mask;
   logic [NUM_BUF-1:0]  full_mask;

   logic                writing_reg,      writing_next;
   logic [IDX_BITS-1:0] wr_idx_reg,       wr_idx_next;
   logic                wr_grant_reg,     wr_grant_next;
   logic [IDX_BITS-1:0] newest_idx_reg,   newest_idx_next;
   logic                newest_valid_reg, newest_valid_next;
   logic [IDX_BITS-1:0] rd_idx_reg,       rd_idx_next;
   logic                rd_valid_reg,     rd_valid_next;
   logic                tg_ready_reg,     tg_ready_next;
   logic                tg_trigger_reg,   tg_trigger_next;
   logic                overrun_reg,      overrun_next;
   logic [15:0]         skip_cnt_reg,     skip_cnt_next;

   logic                done_acc;
   logic                drop_acc;
   logic                eff_newest_valid;
   logic [IDX_BITS-1:0] eff_newest_idx;
   logic                promote;
   logic                repeat_last;

   logic                free_found,  other_found;
   logic [IDX_BITS-1:0] free_idx,    other_idx;
   logic                grant;
   logic [IDX_BITS-1:0] grant_idx;
   logic                took_full;
   logic                steal_newest;

   // ---------------------------------------------------------------------------
   // Writer completion and frame promotion. A wr_done in the same cycle as a
   // frame_tick counts as already complete, so that buffer is promoted at once.
   // ---------------------------------------------------------------------------
   always_comb begin
      done_acc         = writing_reg & sif.wr_done & ~sif.wr_drop;
      drop_acc         = writing_reg & sif.wr_drop;
      eff_newest_valid = newest_valid_reg | done_acc;
      eff_newest_idx   = done_acc ? wr_idx_reg : newest_idx_reg;
      promote          = sif.frame_tick & eff_newest_valid;
`ifdef REPEAT_LAST_EN
      repeat_last      = sif.frame_tick & ~eff_newest_valid & rd_valid_reg;
`else
      repeat_last      = 1'b0;
`endif
   end

   // ---------------------------------------------------------------------------
   // Lowest-index search for a FREE buffer and for a FULL buffer that is not
   // the newest one (a stale frame that has been superseded).
   // ---------------------------------------------------------------------------
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      other_found = 1'b0;
      other_idx   = '0;
      for (int i = NUM_BUF - 1; i >= 0; i--) begin
         if (free_mask[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_BITS'(i);
         end
         if (full_mask[i] && !(newest_valid_reg && (IDX_BITS'(i) == newest_idx_reg))) begin
            other_found = 1'b1;
            other_idx   = IDX_BITS'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Grant selection. Grants only happen while no write is open, so they never
   // coincide with wr_done/wr_drop. On a frame_tick the newest buffer is about
   // to become READING and is withheld; the buffer freed by that tick is still
   // READING here, so it is naturally not a candidate until the next cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant        = 1'b0;
      grant_idx    = '0;
      took_full    = 1'b0;
      steal_newest = 1'b0;
      if (sif.wr_req && !writing_reg) begin
         if (free_found) begin
            grant     = 1'b1;
            grant_idx = free_idx;
         end else if (other_found) begin
            grant     = 1'b1;
            grant_idx = other_idx;
            took_full = 1'b1;
         end else if (newest_valid_reg && !sif.frame_tick) begin
            grant        = 1'b1;
            grant_idx    = newest_idx_reg;
            took_full    = 1'b1;
            steal_newest = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // One state machine per buffer. Update order within a cycle: writer
   // completion/abort, then frame promotion, then grant.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUF; gi++) begin : g_buf
         localparam logic [IDX_BITS-1:0] BUF_IDX = IDX_BITS'(gi);
         buf_state_t state_reg, state_next;

         always_ff @(posedge clk_in or posedge reset) begin
            if (reset) state_reg <= BUF_FREE;
            else       state_reg <= state_next;
         end

         always_comb begin
            state_next = state_reg;
            if (done_acc && (wr_idx_reg == BUF_IDX)) state_next = BUF_FULL;
            if (drop_acc && (wr_idx_reg == BUF_IDX)) state_next = BUF_FREE;
            if (promote) begin
               if (state_reg == BUF_READING)    state_next = BUF_FREE;
               if (eff_newest_idx == BUF_IDX)   state_next = BUF_READING;
            end
            if (grant && (grant_idx == BUF_IDX)) state_next = BUF_WRITING;
         end

         assign free_mask[gi] = (state_reg == BUF_FREE);
         assign full_mask[gi] = (state_reg == BUF_FULL);
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Shared bookkeeping and output registers
   // ---------------------------------------------------------------------------
   always_comb begin
      writing_next = writing_reg;
      if (done_acc || drop_acc) writing_next = 1'b0;
      if (grant)                writing_next = 1'b1;

      wr_idx_next       = grant ? grant_idx : wr_idx_reg;
      wr_grant_next     = grant;
      overrun_next      = grant & took_full;

      newest_idx_next   = eff_newest_idx;
      newest_valid_next = eff_newest_valid & ~promote & ~steal_newest;

      rd_idx_next       = rd_idx_reg;
      rd_valid_next     = rd_valid_reg;
      if (promote) begin
         rd_idx_next   = eff_newest_idx;
         rd_valid_next = 1'b1;
      end

      // tg_ready only moves on frame_tick cycles
      tg_ready_next = tg_ready_reg;
      skip_cnt_next = skip_cnt_reg;
      if (sif.frame_tick) begin
         if (promote || repeat_last) begin
            tg_ready_next = 1'b1;
         end else begin
            tg_ready_next = 1'b0;
            if (skip_cnt_reg != 16'hFFFF) skip_cnt_next = skip_cnt_reg + 16'd1;
         end
      end

      tg_trigger_next = sif.mode_oneshot ? done_acc : 1'b1;
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         writing_reg      <= 1'b0;
         wr_idx_reg       <= '0;
         wr_grant_reg     <= 1'b0;
         newest_idx_reg   <= '0;
         newest_valid_reg <= 1'b0;
         rd_idx_reg       <= '0;
         rd_valid_reg     <= 1'b0;
         tg_ready_reg     <= 1'b0;
         tg_trigger_reg   <= 1'b0;
         overrun_reg      <= 1'b0;
         skip_cnt_reg     <= '0;
      end else begin
         writing_reg      <= writing_next;
         wr_idx_reg       <= wr_idx_next;
         wr_grant_reg     <= wr_grant_next;
         newest_idx_reg   <= newest_idx_next;
         newest_valid_reg <= newest_valid_next;
         rd_idx_reg       <= rd_idx_next;
         rd_valid_reg     <= rd_valid_next;
         tg_ready_reg     <= tg_ready_next;
         tg_trigger_reg   <= tg_trigger_next;
         overrun_reg      <= overrun_next;
         skip_cnt_reg     <= skip_cnt_next;
      end
   end

   assign sif.wr_grant   = wr_grant_reg;
   assign sif.wr_idx     = wr_idx_reg;
   assign sif.tg_ready   = tg_ready_reg;
   assign sif.tg_trigger = tg_trigger_reg;
   assign sif.rd_idx     = rd_idx_reg;
   assign sif.rd_valid   = rd_valid_reg;
   assign sif.overrun    = overrun_reg;
   assign sif.skip_cnt   = skip_cnt_reg;

endmodule

// File: tb/tb_video_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_video_frame_scheduler
//
// Bench for video_frame_scheduler (NUM_BUF=3, IDX_BITS=2): a table of directed
// vectors with hand-derived expectations, a skip counter saturation run,
// randomized traffic against a buffer-ownership model, and an asynchronous
// reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_video_frame_scheduler;

   localparam int NB = 3;
   localparam int IB = 2;
`ifdef REPEAT_LAST_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   localparam int M_FREE = 0, M_WR = 1, M_FULL = 2, M_RD = 3;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   always #5 clk_in = ~clk_in;

   video_frame_scheduler_if #(.IDX_BITS(IB)) sif ();

   video_frame_scheduler #(.NUM_BUF(NB), .IDX_BITS(IB)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .sif    (sif)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic grant, input logic [1:0] widx,
                          input logic ready, input logic [1:0] ridx, input logic rv,
                          input logic ovr, input logic trig, input logic [15:0] skip);
      chk({tag, ".wr_grant"},   16'(sif.wr_grant),   16'(grant));
      chk({tag, ".wr_idx"},     16'(sif.wr_idx),     16'(widx));
      chk({tag, ".tg_ready"},   16'(sif.tg_ready),   16'(ready));
      chk({tag, ".rd_idx"},     16'(sif.rd_idx),     16'(ridx));
      chk({tag, ".rd_valid"},   16'(sif.rd_valid),   16'(rv));
      chk({tag, ".overrun"},    16'(sif.overrun),    16'(ovr));
      chk({tag, ".tg_trigger"}, 16'(sif.tg_trigger), 16'(trig));
      chk({tag, ".skip_cnt"},   sif.skip_cnt,        skip);
   endtask

   task automatic drive(input logic req, input logic done, input logic drop,
                        input logic tick, input logic one);
      sif.wr_req       = req;
      sif.wr_done      = done;
      sif.wr_drop      = drop;
      sif.frame_tick   = tick;
      sif.mode_oneshot = one;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic req, done, drop, tick, one;
      logic grant; logic [1:0] widx; logic ready; logic [1:0] ridx;
      logic rv, ovr, trig; logic [15:0] skip;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic req, done, drop, tick, one, grant,
                      input logic [1:0] widx, input logic ready,
                      input logic [1:0] ridx, input logic rv, ovr, trig,
                      input logic [15:0] skip);
      vec_t v;
      v.req = req; v.done = done; v.drop = drop; v.tick = tick; v.one = one;
      v.grant = grant; v.widx = widx; v.ready = ready; v.ridx = ridx;
      v.rv = rv; v.ovr = ovr; v.trig = trig; v.skip = skip;
      vecs.push_back(v);
   endtask

   // ---------------- reference model ----------------
   // Each buffer carries an owner tag; -1 means "no such buffer".
   int          m_st[NB];
   int          m_writing, m_newest;
   logic        m_grant, m_ready, m_rv, m_ovr, m_trig;
   logic [1:0]  m_widx, m_ridx;
   logic [15:0] m_skip;

   task automatic m_reset();
      foreach (m_st[i]) m_st[i] = M_FREE;
      m_writing = -1; m_newest = -1;
      m_grant = 0; m_ready = 0; m_rv = 0; m_ovr = 0; m_trig = 0;
      m_widx = 0; m_ridx = 0; m_skip = 0;
   endtask

   task automatic m_step(input bit req, done, drop, tick, one);
      int g = -1;
      bit done_hit = 0;
      m_grant = 0;
      m_ovr   = 0;
      // choose against the buffers as they stand at the start of the cycle
      if (req && m_writing < 0) begin
         for (int i = 0; i < NB; i++) if (g < 0 && m_st[i] == M_FREE) g = i;
         for (int i = 0; i < NB; i++) if (g < 0 && m_st[i] == M_FULL && i != m_newest) g = i;
         if (g < 0 && m_newest >= 0 && !tick) g = m_newest;
      end
      if (m_writing >= 0) begin
         if (drop) begin
            m_st[m_writing] = M_FREE; m_writing = -1;
         end else if (done) begin
            m_st[m_writing] = M_FULL; m_newest = m_writing; m_writing = -1; done_hit = 1;
         end
      end
      if (tick) begin
         if (m_newest >= 0) begin
            for (int i = 0; i < NB; i++) if (m_st[i] == M_RD) m_st[i] = M_FREE;
            m_st[m_newest] = M_RD;
            m_ridx = 2'(m_newest); m_rv = 1; m_newest = -1; m_ready = 1;
         end else if (REP && m_rv) begin
            m_ready = 1;
         end else begin
            m_ready = 0;
            if (m_skip < 16'hFFFF) m_skip = m_skip + 16'd1;
         end
      end
      if (g >= 0) begin
         m_ovr = (m_st[g] == M_FULL);
         if (g == m_newest) m_newest = -1;
         m_st[g] = M_WR; m_writing = g; m_widx = 2'(g); m_grant = 1;
      end
      m_trig = one ? done_hit : 1'b1;
   endtask

   initial begin
      logic [15:0] s;
      logic        r;
      bit          rq, dn, dp, tk, on;

      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk_in);
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 16'd0);

      // Expectations after each clock edge; r/s cover the optional repeat mode
      r = REP;
      s = REP ? 16'd0 : 16'd1;
      //   req dn dp tk one | grant widx rdy ridx rv ovr trig skip
      add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0);   // first grant -> buffer 0
      add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 1, 0);   // display buffer 0
      add(0, 0, 0, 1, 0,  0, 0, r, 0, 1, 0, 1, s);   // no new frame -> skip
      add(1, 0, 0, 0, 0,  1, 1, r, 0, 1, 0, 1, s);
      add(0, 1, 0, 0, 0,  0, 1, r, 0, 1, 0, 1, s);
      add(1, 0, 0, 0, 0,  1, 2, r, 0, 1, 0, 1, s);
      add(0, 1, 0, 0, 0,  0, 2, r, 0, 1, 0, 1, s);
      add(1, 0, 0, 0, 0,  1, 1, r, 0, 1, 1, 1, s);   // steal stale FULL 1, overrun
      add(0, 1, 0, 1, 0,  0, 1, 1, 1, 1, 0, 1, s);   // done+tick: buffer 1 shown
      add(1, 0, 0, 0, 0,  1, 0, 1, 1, 1, 0, 1, s);   // freed buffer 0 granted
      add(0, 1, 0, 0, 0,  0, 0, 1, 1, 1, 0, 1, s);
      add(1, 0, 0, 0, 0,  1, 2, 1, 1, 1, 1, 1, s);   // steal stale 2
      add(0, 0, 1, 0, 0,  0, 2, 1, 1, 1, 0, 1, s);   // drop 2
      add(1, 0, 0, 0, 0,  1, 2, 1, 1, 1, 0, 1, s);   // 2 is FREE again
      add(0, 0, 1, 0, 0,  0, 2, 1, 1, 1, 0, 1, s);
      add(0, 0, 0, 1, 0,  0, 2, 1, 0, 1, 0, 1, s);   // newest still 0
      add(1, 0, 0, 0, 1,  1, 1, 1, 0, 1, 0, 0, s);   // one-shot mode
      add(0, 1, 0, 0, 1,  0, 1, 1, 0, 1, 0, 1, s);   // trigger pulse 1
      add(0, 0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 0, s);
      add(1, 0, 0, 0, 1,  1, 2, 1, 0, 1, 0, 0, s);
      add(0, 1, 0, 0, 1,  0, 2, 1, 0, 1, 0, 1, s);   // trigger pulse 2
      add(0, 0, 0, 0, 1,  0, 2, 1, 0, 1, 0, 0, s);
      add(1, 0, 0, 0, 1,  1, 1, 1, 0, 1, 1, 0, s);   // steal stale 1
      add(0, 1, 0, 0, 1,  0, 1, 1, 0, 1, 0, 1, s);   // trigger pulse 3
      add(0, 0, 0, 0, 1,  0, 1, 1, 0, 1, 0, 0, s);
      add(0, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 1, s);   // continuous again
      add(1, 0, 0, 1, 0,  1, 2, 1, 1, 1, 1, 1, s);   // tick+grant: newest withheld
      add(0, 1, 0, 0, 0,  0, 2, 1, 1, 1, 0, 1, s);
      add(0, 0, 0, 1, 0,  0, 2, 1, 2, 1, 0, 1, s);

      reset = 1'b0;
      foreach (vecs[k]) begin
         drive(vecs[k].req, vecs[k].done, vecs[k].drop, vecs[k].tick, vecs[k].one);
         @(posedge clk_in);
         @(negedge clk_in);
         $display("vec %0d: req=%0b done=%0b drop=%0b tick=%0b one=%0b -> grant=%0b widx=%0d ready=%0b ridx=%0d ovr=%0b trig=%0b skip=%0d",
                  k, vecs[k].req, vecs[k].done, vecs[k].drop, vecs[k].tick, vecs[k].one,
                  sif.wr_grant, sif.wr_idx, sif.tg_ready, sif.rd_idx, sif.overrun,
                  sif.tg_trigger, sif.skip_cnt);
         chk_all($sformatf("vec%0d", k), vecs[k].grant, vecs[k].widx, vecs[k].ready,
                 vecs[k].ridx, vecs[k].rv, vecs[k].ovr, vecs[k].trig, vecs[k].skip);
      end

      // ---------------- skip counter saturation ----------------
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      @(negedge clk_in);
      reset = 1'b0;
      drive(0, 0, 0, 1, 0);
      repeat (65534) @(posedge clk_in);
      @(negedge clk_in);
      chk("sat.skip_fffe", sif.skip_cnt, 16'hFFFE);
      chk("sat.ready", 16'(sif.tg_ready), 16'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      chk("sat.skip_ffff", sif.skip_cnt, 16'hFFFF);
      repeat (5) @(posedge clk_in);
      @(negedge clk_in);
      chk("sat.skip_hold", sif.skip_cnt, 16'hFFFF);
      $display("saturation: skip_cnt=%0h", sif.skip_cnt);

      // ---------------- randomized traffic vs model ----------------
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      @(negedge clk_in);
      m_reset();
      reset = 1'b0;
      on = 0;
      for (int c = 0; c < 3000; c++) begin
         rq = ($urandom_range(0, 99) < 55);
         dn = ($urandom_range(0, 99) < 25);
         dp = ($urandom_range(0, 99) < 8);
         tk = ($urandom_range(0, 99) < 15);
         if ($urandom_range(0, 99) < 4) on = ~on;
         drive(rq, dn, dp, tk, on);
         @(posedge clk_in);
         m_step(rq, dn, dp, tk, on);
         @(negedge clk_in);
         if (m_grant)
            $display("rand %0d: grant idx=%0d overrun=%0b rd_idx=%0d skip=%0d",
                     c, m_widx, m_ovr, m_ridx, m_skip);
         chk_all($sformatf("rand%0d", c), m_grant, m_widx, m_ready, m_ridx,
                 m_rv, m_ovr, m_trig, m_skip);
      end

      // ---------------- asynchronous reset during a write ----------------
      drive(1, 0, 0, 0, 0);
      @(posedge clk_in);
      @(negedge clk_in);
      #2 reset = 1'b1;
      #1 chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 16'd0);
      @(negedge clk_in);
      reset = 1'b0;
      drive(1, 0, 0, 0, 0);
      @(posedge clk_in);
      @(negedge clk_in);
      chk("post_reset.wr_grant", 16'(sif.wr_grant), 16'd1);
      chk("post_reset.wr_idx", 16'(sif.wr_idx), 16'd0);
      $display("post reset: grant=%0b idx=%0d", sif.wr_grant, sif.wr_idx);
      drive(0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
